// File: rtl/mem_arbiter_pkg.sv
// Shared types for the main-memory arbiter.
//   state_t   : transaction sequencer states (IDLE -> LO -> [HI] -> FIN)
//   req_id_t  : requester identity (CPU = 0, HOST = 1)
//   other_id  : the requester that is not the given one
//   assemble_rdata : builds the 16-bit read result from the captured bytes
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_CPU  = 1'b0,
    REQ_HOST = 1'b1
  } req_id_t;

  function automatic req_id_t other_id(input req_id_t id);
    return (id == REQ_HOST) ? REQ_CPU : REQ_HOST;
  endfunction

  // Word reads: lo captured earlier, hi arriving now. Byte reads: the byte
  // arriving now is the low byte and the high byte reads as zero.
  function automatic logic [15:0] assemble_rdata(input logic word,
                                                 input logic [7:0] lo,
                                                 input logic [7:0] arriving);
    return word ? {arriving, lo} : {8'h00, arriving};
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester channel of the memory arbiter.
//   req/we/word/addr/wdata : driven by the requester, held stable until ack
//   ack                    : one-cycle completion pulse from the arbiter
//   rdata                  : read result, valid in the ack cycle
// master = requester side, slave = arbiter side.
interface mem_arbiter_if #(
  parameter int AW = 16
) ();

  logic          req;
  logic          we;
  logic          word;
  logic [AW-1:0] addr;
  logic [15:0]   wdata;
  logic          ack;
  logic [15:0]   rdata;

  modport master (
    output req, we, word, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, word, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/mem_arbiter_arb.sv
// rr_arb2: two-way requester picker.
//   req[1:0]  : pending requests, index = req_id_t (0 CPU, 1 HOST)
//   prio_host : 1 -> host wins every tie; 0 -> tie goes to the one not granted last
//   advance   : a grant is being taken this cycle; records it as last_grant
//   grant     : combinational winner (meaningful only when req != 0)
// last_grant resets to HOST so the CPU wins the first tie.
import mem_arbiter_pkg::*;

module rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       prio_host,
  input  logic       advance,
  output req_id_t    grant
);

  req_id_t last_grant;

  always_comb begin
    grant = REQ_CPU;
    if (req == 2'b11) begin
      grant = prio_host ? REQ_HOST : other_id(last_grant);
    end else if (req[1]) begin
      grant = REQ_HOST;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= REQ_HOST;
    end else if (advance) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide memory port between the CPU and the host
// loader/debug port. Word accesses run as two byte cycles, low byte at addr,
// high byte at addr+1 (AW-bit wrap).
//   clock, reset_n : clock (posedge) and asynchronous active-low reset
//   cpu, host      : requester channels (mem_arbiter_if.slave)
//   mem_ren/wen    : memory read/write strobes, never both high
//   mem_addr       : memory byte address, holds last value when idle
//   mem_wdata      : memory write byte, holds last value when idle
//   mem_rdata      : memory read byte, valid one cycle after mem_ren
//   busy           : sequencer not idle
//   gnt_host       : owner of the current/last transaction (0 = CPU)
// All outputs are registered.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int          AW            = 16,
  parameter int unsigned HOST_PRIORITY = 0
) (
  input  logic            clock,
  input  logic            reset_n,
  mem_arbiter_if.slave    cpu,
  mem_arbiter_if.slave    host,
  output logic            mem_ren,
  output logic            mem_wen,
  output logic [AW-1:0]   mem_addr,
  output logic [7:0]      mem_wdata,
  input  logic [7:0]      mem_rdata,
  output logic            busy,
  output logic            gnt_host
);

  state_t        state;
  req_id_t       grant;
  logic          any_req;
  logic          advance;

  // Operands latched at grant time; requester changes after that are ignored.
  logic          op_we;
  logic          op_word;
  logic [AW-1:0] op_addr;
  logic [15:0]   op_wdata;
  logic [7:0]    rlo;
  logic [15:0]   rd_word;

  // Operands of the current winner, selected combinationally in IDLE.
  logic          sel_we;
  logic          sel_word;
  logic [AW-1:0] sel_addr;
  logic [15:0]   sel_wdata;

  assign any_req = cpu.req | host.req;
  assign advance = (state == ST_IDLE) && any_req;

  rr_arb2 u_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       ({host.req, cpu.req}),
    .prio_host (HOST_PRIORITY != 0),
    .advance   (advance),
    .grant     (grant)
  );

  always_comb begin
    sel_we    = cpu.we;
    sel_word  = cpu.word;
    sel_addr  = cpu.addr;
    sel_wdata = cpu.wdata;
    if (grant == REQ_HOST) begin
      sel_we    = host.we;
      sel_word  = host.word;
      sel_addr  = host.addr;
      sel_wdata = host.wdata;
    end
  end

  always_comb begin
    rd_word = assemble_rdata(op_word, rlo, mem_rdata);
  end

  // Strobes/address/data are set on the edge entering LO or HI so that they
  // are valid for the whole cycle the sequencer spends in that state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      op_we      <= 1'b0;
      op_word    <= 1'b0;
      op_addr    <= '0;
      op_wdata   <= '0;
      rlo        <= '0;
      mem_ren    <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      gnt_host   <= 1'b0;
      cpu.ack    <= 1'b0;
      cpu.rdata  <= '0;
      host.ack   <= 1'b0;
      host.rdata <= '0;
    end else begin
      cpu.ack  <= 1'b0;
      host.ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            op_we     <= sel_we;
            op_word   <= sel_word;
            op_addr   <= sel_addr;
            op_wdata  <= sel_wdata;
            gnt_host  <= (grant == REQ_HOST);
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata[7:0];
            mem_ren   <= ~sel_we;
            mem_wen   <= sel_we;
            busy      <= 1'b1;
            state     <= ST_LO;
          end
        end
        ST_LO: begin
          if (op_word) begin
            mem_addr  <= op_addr + AW'(1);
            mem_wdata <= op_wdata[15:8];
            state     <= ST_HI;
          end else begin
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            state     <= ST_FIN;
          end
        end
        ST_HI: begin
          if (!op_we) begin
            rlo <= mem_rdata;
          end
          mem_ren <= 1'b0;
          mem_wen <= 1'b0;
          state   <= ST_FIN;
        end
        ST_FIN: begin
          if (gnt_host) begin
            host.ack <= 1'b1;
            if (!op_we) begin
              host.rdata <= rd_word;
            end
          end else begin
            cpu.ack <= 1'b1;
            if (!op_we) begin
              cpu.rdata <= rd_word;
            end
          end
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
